// File: rtl/seq_divider_param_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
// Operands are zero-extended to DIV_MAX_WIDTH before twos_mag, so WIDTH must stay below it.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_MAX_WIDTH     = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Conditional two's-complement negate; low WIDTH bits give the magnitude of a WIDTH-bit value
  function automatic logic [DIV_MAX_WIDTH-1:0] twos_mag(input logic [DIV_MAX_WIDTH-1:0] x,
                                                         input logic                     neg);
    logic [DIV_MAX_WIDTH-1:0] res;
    if (neg) begin
      res = ~x + {{(DIV_MAX_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = x;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_divider_param_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_param_if #(parameter int WIDTH = 32);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, q, r, div_by_zero
  );

endinterface

// File: rtl/seq_divider_param_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   pr_next,
  output logic             qbit
);

  logic [WIDTH+1:0] t_s;
  logic [WIDTH+1:0] diff_s;
  logic             unused_diff_msb_s;

  // Trial subtraction on a WIDTH+2 bit window so the shifted remainder never overflows
  always_comb begin
    t_s    = {pr, dbit};
    diff_s = t_s - {2'b00, divisor};
    if (t_s >= {2'b00, divisor}) begin
      qbit    = 1'b1;
      pr_next = diff_s[WIDTH:0];
    end else begin
      qbit    = 1'b0;
      pr_next = t_s[WIDTH:0];
    end
  end

  assign unused_diff_msb_s = diff_s[WIDTH+1];

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider (signed/unsigned), one quotient bit per clock.
module seq_divider_param
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  seq_divider_param_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_r;
  div_state_e       state_s;
  logic [CW-1:0]    count_r;
  logic             sign_a_r;
  logic             sign_b_r;
  logic             b_zero_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] mag_b_r;
  logic [WIDTH-1:0] a_orig_r;
  logic [WIDTH:0]   pr_r;
  logic [WIDTH:0]   pr_next_s;
  logic             qbit_s;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;

  logic                     in_sign_a_s;
  logic                     in_sign_b_s;
  logic [DIV_MAX_WIDTH-1:0] mag_a_ext_s;
  logic [DIV_MAX_WIDTH-1:0] mag_b_ext_s;
  logic [DIV_MAX_WIDTH-1:0] fix_q_ext_s;
  logic [DIV_MAX_WIDTH-1:0] fix_r_ext_s;
  logic                     unused_ext_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr_r),
    .dbit    (dvd_r[WIDTH-1]),
    .divisor (mag_b_r),
    .pr_next (pr_next_s),
    .qbit    (qbit_s)
  );

  // Operand magnitudes at acceptance and sign-corrected results at writeback
  always_comb begin
    in_sign_a_s = bus.is_signed & bus.a[WIDTH-1];
    in_sign_b_s = bus.is_signed & bus.b[WIDTH-1];
    mag_a_ext_s = twos_mag(DIV_MAX_WIDTH'(bus.a), in_sign_a_s);
    mag_b_ext_s = twos_mag(DIV_MAX_WIDTH'(bus.b), in_sign_b_s);
    fix_q_ext_s = twos_mag(DIV_MAX_WIDTH'(dvd_r), sign_a_r ^ sign_b_r);
    fix_r_ext_s = twos_mag(DIV_MAX_WIDTH'(pr_r[WIDTH-1:0]), sign_a_r);
  end

  assign unused_ext_s = ^{mag_a_ext_s[DIV_MAX_WIDTH-1:WIDTH], mag_b_ext_s[DIV_MAX_WIDTH-1:WIDTH],
                          fix_q_ext_s[DIV_MAX_WIDTH-1:WIDTH], fix_r_ext_s[DIV_MAX_WIDTH-1:WIDTH]};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == CW'(1)) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: dvd_r shifts dividend bits out at the top and quotient bits in at the bottom
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r  <= {CW{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      dvd_r    <= {WIDTH{1'b0}};
      mag_b_r  <= {WIDTH{1'b0}};
      a_orig_r <= {WIDTH{1'b0}};
      pr_r     <= {(WIDTH+1){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      q_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sign_a_r <= in_sign_a_s;
            sign_b_r <= in_sign_b_s;
            dvd_r    <= mag_a_ext_s[WIDTH-1:0];
            mag_b_r  <= mag_b_ext_s[WIDTH-1:0];
            a_orig_r <= bus.a;
            b_zero_r <= (bus.b == {WIDTH{1'b0}});
            pr_r     <= {(WIDTH+1){1'b0}};
            count_r  <= CW'(WIDTH);
          end else begin
            count_r  <= count_r;
          end
        end
        RUN: begin
          pr_r    <= pr_next_s;
          dvd_r   <= {dvd_r[WIDTH-2:0], qbit_s};
          count_r <= count_r - CW'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          if (b_zero_r) begin
            q_r   <= {WIDTH{1'b1}};
            r_r   <= a_orig_r;
            dbz_r <= 1'b1;
          end else begin
            q_r   <= fix_q_ext_s[WIDTH-1:0];
            r_r   <= fix_r_ext_s[WIDTH-1:0];
            dbz_r <= 1'b0;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.q           = q_r;
  assign bus.r           = r_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_param.sv
// Randomised and directed bench for seq_divider_param at WIDTH=32 and WIDTH=8.
module tb_seq_divider_param;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  seq_divider_param_if #(.WIDTH(32)) bif32 ();
  seq_divider_param_if #(.WIDTH(8))  bif8 ();

  seq_divider_param #(.WIDTH(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bif32));
  seq_divider_param #(.WIDTH(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(bif8));

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int last_done_edge = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cur_busy(input int w);
    return (w == 32) ? 64'(bif32.busy) : 64'(bif8.busy);
  endfunction
  function automatic logic [63:0] cur_done(input int w);
    return (w == 32) ? 64'(bif32.done) : 64'(bif8.done);
  endfunction
  function automatic logic [63:0] cur_q(input int w);
    return (w == 32) ? 64'(bif32.q) : 64'(bif8.q);
  endfunction
  function automatic logic [63:0] cur_r(input int w);
    return (w == 32) ? 64'(bif32.r) : 64'(bif8.r);
  endfunction
  function automatic logic [63:0] cur_dbz(input int w);
    return (w == 32) ? 64'(bif32.div_by_zero) : 64'(bif8.div_by_zero);
  endfunction

  // Reference: plain integer division (SV / and % truncate toward zero)
  function automatic void model(input int w, input bit sgn, input logic [31:0] av_in,
                                input logic [31:0] bv_in, output logic [63:0] eq,
                                output logic [63:0] er, output logic ez);
    longint unsigned m, av, bv;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    av = 64'(av_in) & m;
    bv = 64'(bv_in) & m;
    if (bv == 0) begin
      eq = m; er = av; ez = 1'b1;
    end else if (sgn) begin
      sa = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
      sb = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
      eq = 64'(sa / sb) & m;
      er = 64'(sa % sb) & m;
      ez = 1'b0;
    end else begin
      eq = av / bv; er = av % bv; ez = 1'b0;
    end
  endfunction

  task automatic drive(input int w, input logic st, input logic sgn, input logic [31:0] av,
                       input logic [31:0] bv);
    if (w == 32) begin
      bif32.start = st; bif32.is_signed = sgn; bif32.a = av; bif32.b = bv;
    end else begin
      bif8.start = st; bif8.is_signed = sgn; bif8.a = av[7:0]; bif8.b = bv[7:0];
    end
  endtask

  task automatic start_op(input int w, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input string tag);
    drive(w, 1'b1, sgn, av, bv);
    @(posedge clock); #1;
    drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
    acc_edge = edge_cnt;
    check({tag, ".busy_acc"}, cur_busy(w), 64'd1);
  endtask

  task automatic wait_done(input int w, input logic sgn, input logic [31:0] av,
                           input logic [31:0] bv, input string tag, output int busy_cnt);
    logic [63:0] eq, er;
    logic ez;
    bit got;
    model(w, sgn, av, bv, eq, er, ez);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (cur_done(w) == 64'd1) begin
        got = 1'b1;
        break;
      end
      if (cur_busy(w) == 64'd1) busy_cnt++;
    end
    if (!got) begin
      check({tag, ".timeout"}, 64'd0, 64'd1);
    end else begin
      last_done_edge = edge_cnt;
      check({tag, ".latency"}, 64'(edge_cnt - acc_edge + 1), 64'(w + 2));
      check({tag, ".q"}, cur_q(w), eq);
      check({tag, ".r"}, cur_r(w), er);
      check({tag, ".dbz"}, cur_dbz(w), 64'(ez));
      check({tag, ".busy_done"}, cur_busy(w), 64'd0);
    end
  endtask

  task automatic run_op(input int w, input logic sgn, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
    int bc;
    start_op(w, sgn, av, bv, tag);
    wait_done(w, sgn, av, bv, tag, bc);
    check({tag, ".busy_cycles"}, 64'(bc + 1), 64'(w + 1));
  endtask

  initial begin
    int d1, bc, n;
    logic [31:0] av, bv, mn, msk;
    logic sgn;
    reset_n = 1'b0;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("rst.busy", cur_busy(32), 64'd0);
    check("rst.done", cur_done(32), 64'd0);
    check("rst.q", cur_q(32), 64'd0);
    check("rst.r", cur_r(32), 64'd0);
    check("rst.dbz", cur_dbz(32), 64'd0);
    #11 reset_n = 1'b1;
    @(posedge clock); #1;

    run_op(32, 1'b0, 32'd100, 32'd7, "u100_7");
    run_op(32, 1'b1, -32'sd7, 32'd2, "s-7_2");
    run_op(32, 1'b1, 32'd7, -32'sd2, "s7_-2");
    run_op(32, 1'b1, -32'sd7, -32'sd2, "s-7_-2");
    run_op(32, 1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1");
    run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_-1");
    run_op(8, 1'b0, 32'h5A, 32'h0, "w8_dbz_u");
    run_op(8, 1'b1, 32'h5A, 32'h0, "w8_dbz_s");
    run_op(8, 1'b0, 32'd9, 32'd3, "w8_9_3");

    // Start pulsed mid-run must be dropped; previous result stays visible
    start_op(32, 1'b0, 32'd1000, 32'd3, "hs");
    repeat (4) @(posedge clock);
    #1;
    check("hs.q_hold", cur_q(32), 64'h8000_0000);
    check("hs.r_hold", cur_r(32), 64'd0);
    drive(32, 1'b1, 1'b1, 32'd77, 32'd5);
    @(posedge clock); #1;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    check("hs.busy_mid", cur_busy(32), 64'd1);
    wait_done(32, 1'b0, 32'd1000, 32'd3, "hs", bc);

    // Back-to-back: start in the done cycle
    run_op(32, 1'b0, 32'd123456, 32'd789, "b2b1");
    d1 = last_done_edge;
    run_op(32, 1'b1, -32'sd1000, 32'd37, "b2b2");
    check("b2b.gap", 64'(last_done_edge - d1), 64'd34);
    @(posedge clock); #1;
    check("done.pulse", cur_done(32), 64'd0);

    // Asynchronous reset during iteration 10
    start_op(32, 1'b0, 32'hDEAD_BEEF, 32'd3, "rst_mid");
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.busy", cur_busy(32), 64'd0);
    check("rst_mid.done", cur_done(32), 64'd0);
    check("rst_mid.q", cur_q(32), 64'd0);
    check("rst_mid.r", cur_r(32), 64'd0);
    check("rst_mid.dbz", cur_dbz(32), 64'd0);
    check("rst_mid.q8", cur_q(8), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("rst_mid.hold_done", cur_done(32), 64'd0);
    end
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("rst_mid.no_done", cur_done(32), 64'd0);
    end
    run_op(32, 1'b0, 32'd50, 32'd5, "post_rst");

    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w   = (wi == 0) ? 32 : 8;
      msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      mn  = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
      for (int k = 0; k < 40; k++) begin
        sgn = 1'($urandom);
        av  = $urandom & msk;
        if ($urandom_range(0, 7) == 0) av = mn;
        case ($urandom_range(0, 9))
          0:       bv = 32'd0;
          1:       bv = msk;
          2:       bv = 32'd1;
          3:       bv = $urandom_range(1, 15);
          default: bv = $urandom & msk;
        endcase
        run_op(w, sgn, av, bv, (w == 32) ? "rnd32" : "rnd8");
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(posedge clock); #1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
